// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and constants for the MD sequencer and HI/LO.
//               MDU_MADD_EN enables the multiply-accumulate encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8,
        MADD  = 4'd9,
        MADDU = 4'd10,
        MSUB  = 4'd11,
        MSUBU = 4'd12
    } md_op_t;

    localparam logic [1:0] ENG_IDLE = 2'b00;
    localparam logic [1:0] ENG_MUL  = 2'b01;
    localparam logic [1:0] ENG_DIV  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } mdu_state_t;

    // Encodings that must wait for the engine to go idle.
    function automatic logic is_md_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO: r = 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU:                       r = 1'b1;
`endif
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo
// Description : Architectural HI/LO registers; engine writeback has priority
//               over MTHI/MTLO writes.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wb_en,
    input  logic [2*W-1:0] wb_data,
    input  logic           mthi_en,
    input  logic           mtlo_en,
    input  logic [W-1:0]   mt_data,
    output logic [W-1:0]   hi,
    output logic [W-1:0]   lo
);

    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (wb_en) begin
            {r_hi, r_lo} <= wb_data;
        end else begin
            if (mthi_en) r_hi <= mt_data;
            if (mtlo_en) r_lo <= mt_data;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : E-stage to multiply/divide engine sequencer with HI/LO
//               ownership and MD hazard stall. MDU_MADD_EN adds MADD/MSUB.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_rs,
    input  logic [W-1:0] req_rt,
    input  logic         flush,
    output logic         stall,
    output logic [W-1:0] rd_data,
    output logic         eng_in_valid,
    input  logic         eng_in_ready,
    output logic [1:0]   eng_op,
    output logic         eng_sign,
    output logic [W-1:0] eng_src0,
    output logic [W-1:0] eng_src1,
    input  logic         eng_out_valid,
    output logic         eng_out_ready,
    input  logic [W-1:0] eng_res0,
    input  logic [W-1:0] eng_res1
);
    import mdu_pkg::*;

    mdu_state_t     r_state;
    mdu_state_t     w_next;
    logic [W-1:0]   r_src0;
    logic [W-1:0]   r_src1;
    logic [1:0]     r_eng_op;
    logic           r_sign;
    logic           w_accept;
    logic           w_start;
    logic [1:0]     w_op;
    logic           w_sign;
    logic           w_mthi;
    logic           w_mtlo;
    logic           w_wb_en;
    logic [2*W-1:0] w_wb_data;
    logic [W-1:0]   w_hi;
    logic [W-1:0]   w_lo;
`ifdef MDU_MADD_EN
    logic           w_acc;
    logic           w_sub;
    logic           r_acc;
    logic           r_sub;
`endif

    assign w_accept = req_valid & ~flush & (r_state == IDLE);

    // Divide by zero is dropped at decode so it never reaches the engine.
    always_comb begin
        w_start = 1'b0;
        w_op    = ENG_IDLE;
        w_sign  = 1'b0;
        w_mthi  = 1'b0;
        w_mtlo  = 1'b0;
`ifdef MDU_MADD_EN
        w_acc   = 1'b0;
        w_sub   = 1'b0;
`endif
        case (req_op)
            MULT:  begin w_start = 1'b1; w_op = ENG_MUL; w_sign = 1'b1; end
            MULTU: begin w_start = 1'b1; w_op = ENG_MUL; end
            DIV:   begin w_start = (req_rt != '0); w_op = ENG_DIV; w_sign = 1'b1; end
            DIVU:  begin w_start = (req_rt != '0); w_op = ENG_DIV; end
            MTHI:  w_mthi = 1'b1;
            MTLO:  w_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            MADD:  begin w_start = 1'b1; w_op = ENG_MUL; w_sign = 1'b1; w_acc = 1'b1; end
            MADDU: begin w_start = 1'b1; w_op = ENG_MUL; w_acc = 1'b1; end
            MSUB:  begin w_start = 1'b1; w_op = ENG_MUL; w_sign = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
            MSUBU: begin w_start = 1'b1; w_op = ENG_MUL; w_acc = 1'b1; w_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_start) w_next = ISSUE;
            ISSUE:   if (eng_in_ready)        w_next = WAIT;
            WAIT:    if (eng_out_valid)       w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        eng_in_valid  = (r_state == ISSUE);
        eng_op        = (r_state == ISSUE) ? r_eng_op : ENG_IDLE;
        eng_sign      = (r_state == ISSUE) ? r_sign : 1'b0;
        eng_out_ready = (r_state == WAIT);
        stall         = req_valid & (r_state != IDLE) & is_md_op(req_op);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src0   <= '0;
            r_src1   <= '0;
            r_eng_op <= ENG_IDLE;
            r_sign   <= 1'b0;
`ifdef MDU_MADD_EN
            r_acc    <= 1'b0;
            r_sub    <= 1'b0;
`endif
        end else if (w_accept && w_start) begin
            r_src0   <= req_rs;
            r_src1   <= req_rt;
            r_eng_op <= w_op;
            r_sign   <= w_sign;
`ifdef MDU_MADD_EN
            r_acc    <= w_acc;
            r_sub    <= w_sub;
`endif
        end
    end

    assign eng_src0 = r_src0;
    assign eng_src1 = r_src1;
    assign w_wb_en  = (r_state == WAIT) & eng_out_valid;

`ifdef MDU_MADD_EN
    // Accumulate uses HI/LO as they stand at the writeback edge.
    always_comb begin
        w_wb_data = {eng_res1, eng_res0};
        if (r_acc) begin
            if (r_sub) w_wb_data = {w_hi, w_lo} - {eng_res1, eng_res0};
            else       w_wb_data = {w_hi, w_lo} + {eng_res1, eng_res0};
        end
    end
`else
    assign w_wb_data = {eng_res1, eng_res0};
`endif

    mdu_hilo #(.W(W)) u_hilo (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (w_wb_en),
        .wb_data (w_wb_data),
        .mthi_en (w_accept & w_mthi),
        .mtlo_en (w_accept & w_mtlo),
        .mt_data (req_rs),
        .hi      (w_hi),
        .lo      (w_lo)
    );

    assign rd_data = (req_op == MFHI) ? w_hi : w_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Directed self-checking bench for mdu_ctrl; the engine side
//               is driven by hand with precomputed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [3:0]   req_op;
    logic [W-1:0] req_rs;
    logic [W-1:0] req_rt;
    logic         flush;
    logic         stall;
    logic [W-1:0] rd_data;
    logic         eng_in_valid;
    logic         eng_in_ready;
    logic [1:0]   eng_op;
    logic         eng_sign;
    logic [W-1:0] eng_src0;
    logic [W-1:0] eng_src1;
    logic         eng_out_valid;
    logic         eng_out_ready;
    logic [W-1:0] eng_res0;
    logic [W-1:0] eng_res1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.W(W)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_rs        (req_rs),
        .req_rt        (req_rt),
        .flush         (flush),
        .stall         (stall),
        .rd_data       (rd_data),
        .eng_in_valid  (eng_in_valid),
        .eng_in_ready  (eng_in_ready),
        .eng_op        (eng_op),
        .eng_sign      (eng_sign),
        .eng_src0      (eng_src0),
        .eng_src1      (eng_src1),
        .eng_out_valid (eng_out_valid),
        .eng_out_ready (eng_out_ready),
        .eng_res0      (eng_res0),
        .eng_res1      (eng_res1)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid     = 1'b0;
        req_op        = NONE;
        req_rs        = '0;
        req_rt        = '0;
        flush         = 1'b0;
        eng_in_ready  = 1'b0;
        eng_out_valid = 1'b0;
        eng_res0      = '0;
        eng_res1      = '0;
    endtask

    // Read HI and LO through rd_data without a valid request.
    task automatic peek(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        req_valid = 1'b0;
        req_op    = MFHI;
        #1 chk({tag, "_hi"}, rd_data, exp_hi);
        req_op    = MFLO;
        #1 chk({tag, "_lo"}, rd_data, exp_lo);
        req_op    = NONE;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_in();
        tick();
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_in_valid", {31'd0, eng_in_valid}, 32'd0);
        chk("rst_out_ready", {31'd0, eng_out_ready}, 32'd0);
        chk("rst_eng_op", {30'd0, eng_op}, 32'd0);
        chk("rst_eng_sign", {31'd0, eng_sign}, 32'd0);
        chk("rst_src0", eng_src0, 32'd0);
        chk("rst_src1", eng_src1, 32'd0);
        peek("rst", 32'd0, 32'd0);
        reset = 1'b0;

        // MULT -3 * 5, with MFLO waiting behind it
        req_valid = 1'b1; req_op = MULT; req_rs = 32'hFFFF_FFFD; req_rt = 32'd5;
        #1 chk("t1_start_stall", {31'd0, stall}, 32'd0);
        tick();
        req_op = MFLO; req_rs = '0; req_rt = '0;
        #1;
        chk("t1_in_valid", {31'd0, eng_in_valid}, 32'd1);
        chk("t1_eng_op", {30'd0, eng_op}, 32'd1);
        chk("t1_eng_sign", {31'd0, eng_sign}, 32'd1);
        chk("t1_src0", eng_src0, 32'hFFFF_FFFD);
        chk("t1_src1", eng_src1, 32'd5);
        chk("t1_stall_issue", {31'd0, stall}, 32'd1);
        tick();
        chk("t1_hold_valid", {31'd0, eng_in_valid}, 32'd1);
        chk("t1_hold_src0", eng_src0, 32'hFFFF_FFFD);
        eng_in_ready = 1'b1;
        tick();
        eng_in_ready = 1'b0;
        #1;
        chk("t1_out_ready", {31'd0, eng_out_ready}, 32'd1);
        chk("t1_wait_in_valid", {31'd0, eng_in_valid}, 32'd0);
        chk("t1_wait_eng_op", {30'd0, eng_op}, 32'd0);
        chk("t1_stall_wait", {31'd0, stall}, 32'd1);
        eng_out_valid = 1'b1; eng_res0 = 32'hFFFF_FFF1; eng_res1 = 32'hFFFF_FFFF;
        tick();
        eng_out_valid = 1'b0;
        #1;
        chk("t1_stall_done", {31'd0, stall}, 32'd0);
        chk("t1_mflo", rd_data, 32'hFFFF_FFF1);
        chk("t1_out_ready_idle", {31'd0, eng_out_ready}, 32'd0);
        peek("t1", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // DIVU 100 / 7
        idle_in();
        req_valid = 1'b1; req_op = DIVU; req_rs = 32'd100; req_rt = 32'd7;
        #1 chk("t2_stall", {31'd0, stall}, 32'd0);
        tick();
        idle_in();
        #1;
        chk("t2_eng_op", {30'd0, eng_op}, 32'd2);
        chk("t2_eng_sign", {31'd0, eng_sign}, 32'd0);
        eng_in_ready = 1'b1;
        tick();
        eng_in_ready = 1'b0;
        eng_out_valid = 1'b1; eng_res0 = 32'd14; eng_res1 = 32'd2;
        tick();
        idle_in();
        peek("t2", 32'd2, 32'd14);

        // DIV by zero is dropped
        req_valid = 1'b1; req_op = MTHI; req_rs = 32'h55;
        tick();
        req_op = MTLO;
        tick();
        req_op = DIV; req_rs = 32'd9; req_rt = 32'd0;
        #1 chk("t3_stall", {31'd0, stall}, 32'd0);
        tick();
        idle_in();
        #1 chk("t3_no_issue", {31'd0, eng_in_valid}, 32'd0);
        tick();
        chk("t3_no_issue2", {31'd0, eng_in_valid}, 32'd0);
        peek("t3", 32'h55, 32'h55);

        // flush blocks acceptance, including MT writes
        req_valid = 1'b1; req_op = MULT; req_rs = 32'd3; req_rt = 32'd3; flush = 1'b1;
        tick();
        idle_in();
        #1 chk("t4_no_issue", {31'd0, eng_in_valid}, 32'd0);
        peek("t4a", 32'h55, 32'h55);
        req_valid = 1'b1; req_op = MTHI; req_rs = 32'h1234;
        tick();
        req_op = MTLO; req_rs = 32'h9999; flush = 1'b1;
        tick();
        idle_in();
        peek("t4b", 32'h1234, 32'h55);

        // flush in ISSUE does not abort; then reset in WAIT
        req_valid = 1'b1; req_op = MULTU; req_rs = 32'd2; req_rt = 32'd3;
        tick();
        req_op = MFHI; flush = 1'b1;
        #1;
        chk("t4_flush_issue", {31'd0, eng_in_valid}, 32'd1);
        chk("t4_flush_stall", {31'd0, stall}, 32'd1);
        eng_in_ready = 1'b1;
        tick();
        eng_in_ready = 1'b0;
        chk("t5_in_wait", {31'd0, eng_out_ready}, 32'd1);
        reset = 1'b1;
        idle_in();
        tick();
        reset = 1'b0;
        req_valid = 1'b1; req_op = MFHI;
        #1;
        chk("t5_out_ready", {31'd0, eng_out_ready}, 32'd0);
        chk("t5_stall", {31'd0, stall}, 32'd0);
        chk("t5_in_valid", {31'd0, eng_in_valid}, 32'd0);
        peek("t5", 32'd0, 32'd0);

        // unknown encoding does nothing
        req_valid = 1'b1; req_op = 4'd15; req_rs = 32'hDEAD; req_rt = 32'd1;
        tick();
        idle_in();
        #1 chk("t7_no_issue", {31'd0, eng_in_valid}, 32'd0);
        peek("t7", 32'd0, 32'd0);

        // MADD onto HI:LO = 0:1
        req_valid = 1'b1; req_op = MTLO; req_rs = 32'd1;
        tick();
        req_op = MADD; req_rs = 32'd2; req_rt = 32'd3;
        tick();
        idle_in();
        #1;
`ifdef MDU_MADD_EN
        chk("t6_eng_op", {30'd0, eng_op}, 32'd1);
        chk("t6_eng_sign", {31'd0, eng_sign}, 32'd1);
        eng_in_ready = 1'b1;
        tick();
        eng_in_ready = 1'b0;
        eng_out_valid = 1'b1; eng_res0 = 32'd6; eng_res1 = 32'd0;
        tick();
        idle_in();
        peek("t6", 32'd0, 32'd7);
`else
        chk("t6_no_issue", {31'd0, eng_in_valid}, 32'd0);
        peek("t6", 32'd0, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
